// File: rtl/ysyx_lsu_if.sv
// rtl/ysyx_lsu_if.sv - split read/write memory bus between the LSU (master) and memory (slave)
interface ysyx_lsu_if #(
  parameter int BIT_W = 32
);
  logic [BIT_W-1:0] araddr;
  logic             arvalid;
  logic             arready;
  logic [BIT_W-1:0] rdata;
  logic [1:0]       rresp;
  logic             rvalid;
  logic             rready;
  logic [BIT_W-1:0] awaddr;
  logic             awvalid;
  logic             awready;
  logic [BIT_W-1:0] wdata;
  logic [3:0]       wstrb;
  logic             wvalid;
  logic             wready;
  logic [1:0]       bresp;
  logic             bvalid;
  logic             bready;

  modport master (
    output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );

  modport slave (
    input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );
endinterface

// File: rtl/ysyx_lsu.sv
// rtl/ysyx_lsu.sv - load/store unit bridging EXU requests onto the split read/write bus
// Optional macro YSYX_LSU_MISALIGN_CHECK_EN: reject misaligned half/word accesses without bus activity.
module ysyx_lsu #(
  parameter int BIT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             lsu_avalid,
  input  logic             ren,
  input  logic             wen,
  input  logic [BIT_W-1:0] lsu_addr,
  input  logic [BIT_W-1:0] lsu_mem_wdata,
  input  logic [3:0]       alu_op,
  output logic [BIT_W-1:0] lsu_rdata,
  output logic             lsu_exu_rvalid,
  output logic             lsu_exu_wready,
  output logic             lsu_err,
  ysyx_lsu_if.master       bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RADDR = 3'd1,
    RDATA = 3'd2,
    WREQ  = 3'd3,
    WRESP = 3'd4,
    DONE  = 3'd5,
    HOLD  = 3'd6
  } state_t;

  state_t           state_q, state_d;
  logic [BIT_W-1:0] addr_q, addr_d;
  logic [BIT_W-1:0] wdata_q, wdata_d;
  logic [2:0]       funct3_q, funct3_d;
  logic             is_store_q, is_store_d;
  logic             aw_done_q, aw_done_d;
  logic             w_done_q, w_done_d;
  logic [BIT_W-1:0] rdata_q, rdata_d;
  logic             err_q, err_d;

  logic             accept;
  logic             aw_hs;
  logic             w_hs;
  logic [4:0]       byte_shift;
  logic [BIT_W-1:0] rdata_shifted;
  logic [BIT_W-1:0] load_ext;
  logic [3:0]       strb_base;
  logic             unused_alu_op;

  assign unused_alu_op = alu_op[3];
  assign accept        = lsu_avalid && (ren || wen);
  assign byte_shift    = {addr_q[1:0], 3'b000};
  assign aw_hs         = bus.awvalid && bus.awready;
  assign w_hs          = bus.wvalid && bus.wready;

`ifdef YSYX_LSU_MISALIGN_CHECK_EN
  logic req_misaligned;
  assign req_misaligned = ((alu_op[1:0] == 2'b01) && lsu_addr[0]) ||
                          ((alu_op[1:0] == 2'b10) && (lsu_addr[1:0] != 2'b00));
`endif

  always_comb begin
    rdata_shifted = bus.rdata >> byte_shift;
    case (funct3_q)
      3'b000:  load_ext = {{(BIT_W-8){rdata_shifted[7]}}, rdata_shifted[7:0]};
      3'b001:  load_ext = {{(BIT_W-16){rdata_shifted[15]}}, rdata_shifted[15:0]};
      3'b100:  load_ext = {{(BIT_W-8){1'b0}}, rdata_shifted[7:0]};
      3'b101:  load_ext = {{(BIT_W-16){1'b0}}, rdata_shifted[15:0]};
      default: load_ext = rdata_shifted;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      funct3_q   <= 3'b000;
      is_store_q <= 1'b0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      funct3_q   <= funct3_d;
      is_store_q <= is_store_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = wen ? WREQ : RADDR;
`ifdef YSYX_LSU_MISALIGN_CHECK_EN
          if (req_misaligned) state_d = DONE;
`endif
        end
      end
      RADDR:   if (bus.arready) state_d = RDATA;
      RDATA:   if (bus.rvalid) state_d = DONE;
      WREQ:    if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) state_d = WRESP;
      WRESP:   if (bus.bvalid) state_d = DONE;
      DONE:    state_d = lsu_avalid ? HOLD : IDLE;
      HOLD:    if (!lsu_avalid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request fields are only captured in IDLE, so they stay stable through DONE.
  always_comb begin
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    funct3_d   = funct3_q;
    is_store_d = is_store_q;
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          addr_d     = lsu_addr;
          wdata_d    = lsu_mem_wdata;
          funct3_d   = alu_op[2:0];
          is_store_d = wen;
          aw_done_d  = 1'b0;
          w_done_d   = 1'b0;
          err_d      = 1'b0;
`ifdef YSYX_LSU_MISALIGN_CHECK_EN
          if (req_misaligned) begin
            err_d = 1'b1;
            if (!wen) rdata_d = '0;
          end
`endif
        end
      end
      RDATA: begin
        if (bus.rvalid) begin
          rdata_d = load_ext;
          err_d   = |bus.rresp;
        end
      end
      WREQ: begin
        aw_done_d = aw_done_q || aw_hs;
        w_done_d  = w_done_q || w_hs;
      end
      WRESP:   if (bus.bvalid) err_d = |bus.bresp;
      default: ;
    endcase
  end

  always_comb begin
    case (funct3_q[1:0])
      2'b00:   strb_base = 4'b0001;
      2'b01:   strb_base = 4'b0011;
      default: strb_base = 4'b1111;
    endcase
    bus.araddr     = {addr_q[BIT_W-1:2], 2'b00};
    bus.arvalid    = (state_q == RADDR);
    bus.rready     = (state_q == RDATA);
    bus.awaddr     = {addr_q[BIT_W-1:2], 2'b00};
    bus.awvalid    = (state_q == WREQ) && !aw_done_q;
    bus.wvalid     = (state_q == WREQ) && !w_done_q;
    bus.wdata      = wdata_q << byte_shift;
    bus.wstrb      = (state_q == WREQ) ? (strb_base << addr_q[1:0]) : 4'b0000;
    bus.bready     = (state_q == WRESP);
    lsu_exu_rvalid = (state_q == DONE) && !is_store_q;
    lsu_exu_wready = (state_q == DONE) && is_store_q;
    lsu_err        = (state_q == DONE) && err_q;
    lsu_rdata      = rdata_q;
  end

endmodule

// File: tb/tb_ysyx_lsu.sv
// tb/tb_ysyx_lsu.sv - directed self-checking bench for ysyx_lsu
module tb_ysyx_lsu;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        lsu_avalid;
  logic        ren;
  logic        wen;
  logic [31:0] lsu_addr;
  logic [31:0] lsu_mem_wdata;
  logic [3:0]  alu_op;
  logic [31:0] lsu_rdata;
  logic        lsu_exu_rvalid;
  logic        lsu_exu_wready;
  logic        lsu_err;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  ysyx_lsu_if #(.BIT_W(32)) bus_if ();

  ysyx_lsu #(.BIT_W(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .lsu_avalid     (lsu_avalid),
    .ren            (ren),
    .wen            (wen),
    .lsu_addr       (lsu_addr),
    .lsu_mem_wdata  (lsu_mem_wdata),
    .alu_op         (alu_op),
    .lsu_rdata      (lsu_rdata),
    .lsu_exu_rvalid (lsu_exu_rvalid),
    .lsu_exu_wready (lsu_exu_wready),
    .lsu_err        (lsu_err),
    .bus            (bus_if)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus;
    bus_if.arready = 1'b0;
    bus_if.rdata   = 32'h0;
    bus_if.rresp   = 2'b00;
    bus_if.rvalid  = 1'b0;
    bus_if.awready = 1'b0;
    bus_if.wready  = 1'b0;
    bus_if.bresp   = 2'b00;
    bus_if.bvalid  = 1'b0;
  endtask

  task automatic req(input logic r, input logic w, input logic [31:0] a,
                     input logic [31:0] d, input logic [3:0] op);
    lsu_avalid    = 1'b1;
    ren           = r;
    wen           = w;
    lsu_addr      = a;
    lsu_mem_wdata = d;
    alu_op        = op;
  endtask

  // Zero-wait load: arready and rvalid offered together, done pulse 3 cycles after accept.
  task automatic do_load(input string tag, input logic [31:0] a, input logic [3:0] op,
                         input logic [31:0] bus_data, input logic [31:0] exp_data);
    req(1'b1, 1'b0, a, 32'h0, op);
    tick;
    chk({tag, "_arvalid"}, {31'b0, bus_if.arvalid}, 32'd1);
    bus_if.arready = 1'b1;
    bus_if.rvalid  = 1'b1;
    bus_if.rdata   = bus_data;
    lsu_avalid     = 1'b0;
    tick;
    chk({tag, "_early_pulse"}, {31'b0, lsu_exu_rvalid}, 32'd0);
    tick;
    chk({tag, "_pulse"}, {31'b0, lsu_exu_rvalid}, 32'd1);
    chk({tag, "_rdata"}, lsu_rdata, exp_data);
    chk({tag, "_err"}, {31'b0, lsu_err}, 32'd0);
    idle_bus;
    tick;
    chk({tag, "_pulse_end"}, {31'b0, lsu_exu_rvalid}, 32'd0);
    chk({tag, "_rdata_hold"}, lsu_rdata, exp_data);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    lsu_avalid    = 1'b0;
    ren           = 1'b0;
    wen           = 1'b0;
    lsu_addr      = 32'h0;
    lsu_mem_wdata = 32'h0;
    alu_op        = 4'h0;
    idle_bus;
    #12;
    chk("rst_arvalid", {31'b0, bus_if.arvalid}, 32'd0);
    chk("rst_rready",  {31'b0, bus_if.rready},  32'd0);
    chk("rst_awvalid", {31'b0, bus_if.awvalid}, 32'd0);
    chk("rst_wvalid",  {31'b0, bus_if.wvalid},  32'd0);
    chk("rst_bready",  {31'b0, bus_if.bready},  32'd0);
    chk("rst_wstrb",   {28'b0, bus_if.wstrb},   32'd0);
    chk("rst_araddr",  bus_if.araddr, 32'd0);
    chk("rst_awaddr",  bus_if.awaddr, 32'd0);
    chk("rst_wdata",   bus_if.wdata,  32'd0);
    chk("rst_rdata",   lsu_rdata,     32'd0);
    chk("rst_err",     {31'b0, lsu_err}, 32'd0);
    chk("rst_pulses",  {30'b0, lsu_exu_rvalid, lsu_exu_wready}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // LW, word-aligned, zero-wait
    req(1'b1, 1'b0, 32'h8000_0004, 32'h0, 4'd2);
    chk("lw_idle_arvalid", {31'b0, bus_if.arvalid}, 32'd0);
    tick;
    chk("lw_arvalid", {31'b0, bus_if.arvalid}, 32'd1);
    chk("lw_araddr", bus_if.araddr, 32'h8000_0004);
    bus_if.arready = 1'b1;
    bus_if.rvalid  = 1'b1;
    bus_if.rdata   = 32'hDEAD_BEEF;
    lsu_avalid     = 1'b0;
    tick;
    chk("lw_rready", {31'b0, bus_if.rready}, 32'd1);
    chk("lw_arvalid_drop", {31'b0, bus_if.arvalid}, 32'd0);
    chk("lw_early_pulse", {31'b0, lsu_exu_rvalid}, 32'd0);
    tick;
    chk("lw_pulse", {31'b0, lsu_exu_rvalid}, 32'd1);
    chk("lw_rdata", lsu_rdata, 32'hDEAD_BEEF);
    chk("lw_err", {31'b0, lsu_err}, 32'd0);
    idle_bus;
    tick;
    chk("lw_pulse_end", {31'b0, lsu_exu_rvalid}, 32'd0);
    chk("lw_rdata_hold", lsu_rdata, 32'hDEAD_BEEF);

    do_load("lb",  32'h8000_0003, 4'd0, 32'h8011_2233, 32'hFFFF_FF80);
    do_load("lbu", 32'h8000_0003, 4'd4, 32'h8011_2233, 32'h0000_0080);
    do_load("lh",  32'h8000_0002, 4'd1, 32'h8001_2233, 32'hFFFF_8001);
    do_load("lhu", 32'h8000_0002, 4'd5, 32'h8001_2233, 32'h0000_8001);
    do_load("lb0", 32'h8000_0000, 4'd0, 32'h1122_3344, 32'h0000_0044);

    // SH at byte 2, aw handshake two cycles after w handshake
    req(1'b0, 1'b1, 32'h8000_0002, 32'h0000_ABCD, 4'd1);
    tick;
    chk("sh_awvalid", {31'b0, bus_if.awvalid}, 32'd1);
    chk("sh_wvalid",  {31'b0, bus_if.wvalid},  32'd1);
    chk("sh_wdata",   bus_if.wdata, 32'hABCD_0000);
    chk("sh_wstrb",   {28'b0, bus_if.wstrb}, 32'hC);
    bus_if.wready = 1'b1;
    lsu_avalid    = 1'b0;
    tick;
    chk("sh_wvalid_drop", {31'b0, bus_if.wvalid}, 32'd0);
    chk("sh_awvalid_hold", {31'b0, bus_if.awvalid}, 32'd1);
    chk("sh_no_bready", {31'b0, bus_if.bready}, 32'd0);
    bus_if.wready = 1'b0;
    tick;
    chk("sh_awvalid_hold2", {31'b0, bus_if.awvalid}, 32'd1);
    bus_if.awready = 1'b1;
    tick;
    chk("sh_awvalid_drop", {31'b0, bus_if.awvalid}, 32'd0);
    chk("sh_bready", {31'b0, bus_if.bready}, 32'd1);
    chk("sh_early_pulse", {31'b0, lsu_exu_wready}, 32'd0);
    bus_if.awready = 1'b0;
    bus_if.bvalid  = 1'b1;
    tick;
    chk("sh_pulse", {31'b0, lsu_exu_wready}, 32'd1);
    chk("sh_no_rvalid", {31'b0, lsu_exu_rvalid}, 32'd0);
    chk("sh_err", {31'b0, lsu_err}, 32'd0);
    idle_bus;
    tick;
    chk("sh_pulse_end", {31'b0, lsu_exu_wready}, 32'd0);

    // Load with SLVERR, lsu_avalid held high after done
    req(1'b1, 1'b0, 32'h8000_0008, 32'h0, 4'd2);
    tick;
    bus_if.arready = 1'b1;
    bus_if.rvalid  = 1'b1;
    bus_if.rresp   = 2'b10;
    bus_if.rdata   = 32'h0BAD_0BAD;
    tick;
    tick;
    chk("err_pulse", {31'b0, lsu_exu_rvalid}, 32'd1);
    chk("err_flag", {31'b0, lsu_err}, 32'd1);
    idle_bus;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("hold_no_arvalid", {31'b0, bus_if.arvalid}, 32'd0);
      chk("hold_no_pulse", {31'b0, lsu_exu_rvalid}, 32'd0);
    end
    lsu_avalid = 1'b0;
    tick;
    tick;
    chk("hold_release_arvalid", {31'b0, bus_if.arvalid}, 32'd0);

    // Misaligned LW
    req(1'b1, 1'b0, 32'h8000_0001, 32'h0, 4'd2);
    tick;
`ifdef YSYX_LSU_MISALIGN_CHECK_EN
    chk("mis_no_arvalid", {31'b0, bus_if.arvalid}, 32'd0);
    chk("mis_pulse", {31'b0, lsu_exu_rvalid}, 32'd1);
    chk("mis_err", {31'b0, lsu_err}, 32'd1);
    chk("mis_rdata", lsu_rdata, 32'd0);
    lsu_avalid = 1'b0;
    tick;
    chk("mis_pulse_end", {31'b0, lsu_exu_rvalid}, 32'd0);
`else
    chk("mis_arvalid", {31'b0, bus_if.arvalid}, 32'd1);
    chk("mis_araddr", bus_if.araddr, 32'h8000_0000);
    bus_if.arready = 1'b1;
    bus_if.rvalid  = 1'b1;
    bus_if.rdata   = 32'h1122_3344;
    lsu_avalid     = 1'b0;
    tick;
    tick;
    chk("mis_pulse", {31'b0, lsu_exu_rvalid}, 32'd1);
    chk("mis_err", {31'b0, lsu_err}, 32'd0);
    chk("mis_rdata", lsu_rdata, 32'h0011_2233);
    idle_bus;
    tick;
`endif

    // Reset while in RDATA, then a fresh SW
    req(1'b1, 1'b0, 32'h8000_0010, 32'h0, 4'd2);
    tick;
    bus_if.arready = 1'b1;
    tick;
    chk("rd_rready_before_rst", {31'b0, bus_if.rready}, 32'd1);
    rst = 1'b0;
    #1;
    chk("mid_rst_rready", {31'b0, bus_if.rready}, 32'd0);
    chk("mid_rst_arvalid", {31'b0, bus_if.arvalid}, 32'd0);
    chk("mid_rst_rdata", lsu_rdata, 32'd0);
    chk("mid_rst_araddr", bus_if.araddr, 32'd0);
    chk("mid_rst_pulse", {31'b0, lsu_exu_rvalid}, 32'd0);
    idle_bus;
    lsu_avalid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    req(1'b0, 1'b1, 32'h8000_0008, 32'h1234_5678, 4'd2);
    tick;
    chk("sw_awvalid", {31'b0, bus_if.awvalid}, 32'd1);
    chk("sw_wvalid", {31'b0, bus_if.wvalid}, 32'd1);
    chk("sw_awaddr", bus_if.awaddr, 32'h8000_0008);
    chk("sw_wdata", bus_if.wdata, 32'h1234_5678);
    chk("sw_wstrb", {28'b0, bus_if.wstrb}, 32'hF);
    bus_if.awready = 1'b1;
    bus_if.wready  = 1'b1;
    lsu_avalid     = 1'b0;
    tick;
    chk("sw_bready", {31'b0, bus_if.bready}, 32'd1);
    chk("sw_valids_drop", {30'b0, bus_if.awvalid, bus_if.wvalid}, 32'd0);
    bus_if.awready = 1'b0;
    bus_if.wready  = 1'b0;
    bus_if.bvalid  = 1'b1;
    tick;
    chk("sw_pulse", {31'b0, lsu_exu_wready}, 32'd1);
    chk("sw_err", {31'b0, lsu_err}, 32'd0);
    idle_bus;
    tick;
    chk("sw_pulse_end", {31'b0, lsu_exu_wready}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
